conv_out_requant: RTL and testbench



---
 rtl/conv_pkg.sv | 18 +
 rtl/requant_sat.sv | 46 ++++
 rtl/conv_out_requant.sv | 137 +++++++++++++
 tb/tb_conv_out_requant.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution output requantization stage.
package conv_pkg;

    localparam int DW_DEF = 22;
    localparam int OW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int ceil_words(input int n, input int pack);
        return (n + pack - 1) / pack;
    endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational round-half-up arithmetic shift plus saturation of one sum to OW bits.
// RELU_EN selects unsigned clamp-at-zero output instead of signed saturation.
module requant_sat
    import conv_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF
) (
    input  logic signed [DW-1:0] sum,
    input  logic        [4:0]    shift,
    output logic        [OW-1:0] q
);

    // One extra bit keeps the rounding addend from overflowing.
    function automatic logic signed [DW:0] round_shift(input logic signed [DW-1:0] v,
                                                       input logic [4:0] sh);
        logic signed [DW:0] ext;
        logic signed [DW:0] rnd;
        ext = {v[DW-1], v};
        rnd = '0;
        if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
        return (ext + rnd) >>> sh;
    endfunction

`ifdef RELU_EN
    localparam logic signed [DW:0] UMAX = {{(DW-OW+1){1'b0}}, {OW{1'b1}}};

    function automatic logic [OW-1:0] saturate(input logic signed [DW:0] r);
        if (r < 0)         return '0;
        else if (r > UMAX) return '1;
        else               return r[OW-1:0];
    endfunction
`else
    localparam logic signed [DW:0] SMAX = {{(DW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [DW:0] SMIN = {{(DW-OW+2){1'b1}}, {(OW-1){1'b0}}};

    function automatic logic [OW-1:0] saturate(input logic signed [DW:0] r);
        if (r > SMAX)      return {1'b0, {(OW-1){1'b1}}};
        else if (r < SMIN) return {1'b1, {(OW-1){1'b0}}};
        else               return r[OW-1:0];
    endfunction
`endif

    assign q = saturate(round_shift(sum, shift));

endmodule

// File: rtl/conv_out_requant.sv
// Requantizes final accumulator sums and writes them PACK-per-word as a burst to the
// output feature RAM. Build with RELU_EN for unsigned ReLU-clamped output.
module conv_out_requant
    import conv_pkg::*;
#(
    parameter int AW   = 8,
    parameter int DW   = DW_DEF,
    parameter int OW   = OW_DEF,
    parameter int PACK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        base,
    input  logic [7:0]           size,
    input  logic [4:0]           shift,
    input  logic                 start,
    input  logic signed [DW-1:0] s_sum,
    input  logic                 s_valid,
    output logic [AW-1:0]        w_addr,
    output logic                 w_en,
    output logic [OW*PACK-1:0]   w_data,
    output logic                 busy,
    output logic                 done
);

    state_t                 state;
    logic [AW-1:0]          base_q;
    logic [7:0]             size_q;
    logic [4:0]             shift_q;
    logic [7:0]             acc_cnt;
    logic [7:0]             elem_cnt;
    logic [7:0]             words_left;
    logic [AW-1:0]          word_cnt;
    logic [OW-1:0]          q_p0;
    logic [OW-1:0]          val_p1;
    logic                   vld_p1;
    logic                   wr_pend_p2;
    logic [PACK-1:0][OW-1:0] pack_p2;
    logic [PACK-1:0][OW-1:0] pack_nxt;
    logic                   accept;
    logic                   tile_go;
    logic                   last_p1;
    logic [7:0]             lane;

    requant_sat #(.DW(DW), .OW(OW)) u_sat (
        .sum   (s_sum),
        .shift (shift_q),
        .q     (q_p0)
    );

    assign accept  = (state == RUN) && s_valid && (acc_cnt != size_q);
    // A start coinciding with the done pulse belongs to the finished tile and is dropped.
    assign tile_go = (state == IDLE) && start && !done;
    assign lane    = elem_cnt & 8'(PACK - 1);
    assign last_p1 = vld_p1 && ((lane == 8'(PACK - 1)) || (elem_cnt + 8'd1 == size_q));

    always_comb begin
        pack_nxt = wr_pend_p2 ? '0 : pack_p2;
        for (int i = 0; i < PACK; i++) begin
            if (vld_p1 && (lane == 8'(i))) pack_nxt[i] = val_p1;
        end
    end

    // stage p1: requantized element; stage p2: pack register
    always_ff @(posedge clk) begin
        if (accept) val_p1 <= q_p0;
        pack_p2 <= tile_go ? '0 : pack_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base_q     <= '0;
            size_q     <= '0;
            shift_q    <= '0;
            acc_cnt    <= '0;
            elem_cnt   <= '0;
            words_left <= '0;
            word_cnt   <= '0;
            vld_p1     <= 1'b0;
            wr_pend_p2 <= 1'b0;
            w_en       <= 1'b0;
            w_addr     <= '0;
            w_data     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            vld_p1     <= accept;
            wr_pend_p2 <= last_p1;
            w_en       <= 1'b0;
            done       <= 1'b0;
            if (vld_p1) elem_cnt <= elem_cnt + 8'd1;
            if (wr_pend_p2) begin
                w_en       <= 1'b1;
                w_addr     <= base_q + word_cnt;
                w_data     <= pack_p2;
                word_cnt   <= word_cnt + 1'b1;
                words_left <= words_left - 8'd1;
            end
            case (state)
                IDLE: begin
                    if (tile_go) begin
                        base_q     <= base;
                        size_q     <= size;
                        shift_q    <= shift;
                        acc_cnt    <= '0;
                        elem_cnt   <= '0;
                        word_cnt   <= '0;
                        words_left <= 8'(ceil_words(int'(size), PACK));
                        if (size == 8'd0) begin
                            state <= DONE;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + 8'd1;
                        if (acc_cnt + 8'd1 == size_q) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (wr_pend_p2 && (words_left == 8'd1)) state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_out_requant.sv
// Directed self-checking bench for conv_out_requant; expectations follow RELU_EN.
module tb_conv_out_requant;

    localparam int AW   = 8;
    localparam int DW   = 22;
    localparam int OW   = 8;
    localparam int PACK = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [AW-1:0]        base;
    logic [7:0]           size;
    logic [4:0]           shift;
    logic                 start;
    logic signed [DW-1:0] s_sum;
    logic                 s_valid;
    logic [AW-1:0]        w_addr;
    logic                 w_en;
    logic [OW*PACK-1:0]   w_data;
    logic                 busy;
    logic                 done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int wr0, dn0, start_cyc, last_vld_cyc;

    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];
    int            wc_q[$];
    logic [AW-1:0] ea[4];
    logic [31:0]   ed[4];

    conv_out_requant #(.AW(AW), .DW(DW), .OW(OW), .PACK(PACK)) dut (
        .clk     (clk),
        .rst     (rst),
        .base    (base),
        .size    (size),
        .shift   (shift),
        .start   (start),
        .s_sum   (s_sum),
        .s_valid (s_valid),
        .w_addr  (w_addr),
        .w_en    (w_en),
        .w_data  (w_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (w_en) begin
            wa_q.push_back(w_addr);
            wd_q.push_back(w_data);
            wc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        wr0 = wa_q.size();
        dn0 = done_cnt;
    endtask

    task automatic start_tile(input logic [AW-1:0] b, input logic [7:0] sz, input logic [4:0] sh);
        base      = b;
        size      = sz;
        shift     = sh;
        start     = 1'b1;
        start_cyc = cyc;
        step();
        start     = 1'b0;
    endtask

    task automatic feed(input logic signed [DW-1:0] v, input int gap);
        s_sum        = v;
        s_valid      = 1'b1;
        last_vld_cyc = cyc;
        step();
        s_valid      = 1'b0;
        repeat (gap) step();
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == dn0 && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt != dn0), 64'd1);
        repeat (4) step();
        chk({tag, "_done_once"}, 64'(done_cnt - dn0), 64'd1);
        chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic expect_words(input string tag, input int n);
        chk({tag, "_nwr"}, 64'(wa_q.size() - wr0), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (wr0 + i < wa_q.size()) begin
                chk({tag, "_addr"}, 64'(wa_q[wr0 + i]), 64'(ea[i]));
                chk({tag, "_data"}, 64'(wd_q[wr0 + i]), 64'(ed[i]));
            end
        end
    endtask

    initial begin
        rst = 1'b1; base = '0; size = '0; shift = '0; start = 1'b0;
        s_sum = '0; s_valid = 1'b0;
        repeat (3) step();
        chk("rst_w_en",   64'(w_en),   64'd0);
        chk("rst_w_addr", 64'(w_addr), 64'd0);
        chk("rst_w_data", 64'(w_data), 64'd0);
        chk("rst_busy",   64'(busy),   64'd0);
        chk("rst_done",   64'(done),   64'd0);
        rst = 1'b0;
        step();

        // shift 4: 100->6, -50->-3, 8->1, 7->0
        mark();
        start_tile(8'h10, 8'd4, 5'd4);
        chk("t1_busy", 64'(busy), 64'd1);
        feed(DW'(100), 0); feed(DW'(-50), 0); feed(DW'(8), 0); feed(DW'(7), 0);
        wait_done("t1");
        ea = '{8'h10, 8'h00, 8'h00, 8'h00};
`ifdef RELU_EN
        ed = '{32'h0001_0006, 32'h0, 32'h0, 32'h0};
`else
        ed = '{32'h0001_FD06, 32'h0, 32'h0, 32'h0};
`endif
        expect_words("t1", 1);
        if (wc_q.size() > wr0) begin
            chk("t1_latency",  64'(wc_q[wr0] - last_vld_cyc), 64'd3);
            chk("t1_done_gap", 64'(done_cyc - wc_q[wr0]),     64'd1);
        end

        // shift 2: 5000->1250 saturates, -5000->-1250
        mark();
        start_tile(8'h20, 8'd2, 5'd2);
        feed(DW'(5000), 0); feed(DW'(-5000), 0);
        wait_done("t2");
        ea = '{8'h20, 8'h00, 8'h00, 8'h00};
`ifdef RELU_EN
        ed = '{32'h0000_00FF, 32'h0, 32'h0, 32'h0};
`else
        ed = '{32'h0000_807F, 32'h0, 32'h0, 32'h0};
`endif
        expect_words("t2", 1);

        // shift 0: -200, 127, 300
        mark();
        start_tile(8'h30, 8'd3, 5'd0);
        feed(DW'(-200), 0); feed(DW'(127), 0); feed(DW'(300), 0);
        wait_done("t3");
        ea = '{8'h30, 8'h00, 8'h00, 8'h00};
`ifdef RELU_EN
        ed = '{32'h00FF_7F00, 32'h0, 32'h0, 32'h0};
`else
        ed = '{32'h007F_7F80, 32'h0, 32'h0, 32'h0};
`endif
        expect_words("t3", 1);

        // ten elements across an address wrap
        mark();
        start_tile(8'hFE, 8'd10, 5'd0);
        for (int i = 1; i <= 10; i++) feed(DW'(i), 0);
        wait_done("t4");
        ea = '{8'hFE, 8'hFF, 8'h00, 8'h00};
        ed = '{32'h0403_0201, 32'h0807_0605, 32'h0000_0A09, 32'h0};
        expect_words("t4", 3);

        // empty tile, then a start landing on the done pulse
        mark();
        start_tile(8'h40, 8'd0, 5'd0);
        step();
        base  = 8'h44;
        size  = 8'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_start_on_done_busy", 64'(busy), 64'd0);
        repeat (6) step();
        chk("t5_done_lat",  64'(done_cyc - start_cyc), 64'd2);
        chk("t5_done_once", 64'(done_cnt - dn0),       64'd1);
        chk("t5_nwr",       64'(wa_q.size() - wr0),    64'd0);

        // gapped input with a stray start mid-tile
        mark();
        start_tile(8'h30, 8'd3, 5'd0);
        feed(DW'(-200), 3);
        base = 8'h50; size = 8'd1; shift = 5'd5; start = 1'b1;
        step();
        start = 1'b0;
        chk("t6_busy", 64'(busy), 64'd1);
        feed(DW'(127), 3); feed(DW'(300), 3);
        wait_done("t6");
        ea = '{8'h30, 8'h00, 8'h00, 8'h00};
`ifdef RELU_EN
        ed = '{32'h00FF_7F00, 32'h0, 32'h0, 32'h0};
`else
        ed = '{32'h007F_7F80, 32'h0, 32'h0, 32'h0};
`endif
        expect_words("t6", 1);

        // reset after two elements, then a clean tile
        mark();
        start_tile(8'h60, 8'd4, 5'd0);
        feed(DW'(1), 0); feed(DW'(2), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t7_w_en",   64'(w_en),   64'd0);
        chk("t7_w_addr", 64'(w_addr), 64'd0);
        chk("t7_w_data", 64'(w_data), 64'd0);
        chk("t7_busy",   64'(busy),   64'd0);
        chk("t7_done",   64'(done),   64'd0);
        feed(DW'(3), 0); feed(DW'(4), 0);
        repeat (6) step();
        chk("t7_nwr",  64'(wa_q.size() - wr0), 64'd0);
        chk("t7_ndone", 64'(done_cnt - dn0),   64'd0);
        mark();
        start_tile(8'h70, 8'd4, 5'd0);
        feed(DW'(5), 0); feed(DW'(6), 0); feed(DW'(7), 0); feed(DW'(8), 0);
        wait_done("t8");
        ea = '{8'h70, 8'h00, 8'h00, 8'h00};
        ed = '{32'h0807_0605, 32'h0, 32'h0, 32'h0};
        expect_words("t8", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
